// File: rtl/he_mem_port_arbiter.sv
// he_mem_port_arbiter
// Shares one single-port memory bus between a read channel and a write channel.
// One transaction is in flight at a time. When both channels request, the channel
// that owned the bus last keeps it until it has completed MAX_BURST grants in a row,
// and then the other channel gets the bus. Strobes, address and write data are
// registered. The completion path back to the requesters is combinational.
// DATA_W defaults to the project-wide 32-bit datapath width.

module he_mem_port_arbiter #(
    parameter int MAX_BURST = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_resp_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i,
    output logic              idle_o,
    output logic              err_o
);

    // The streak counter saturates at MAX_BURST, so it only needs to hold 0..MAX_BURST
    localparam int STREAK_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_BUSY = 2'd1;
    localparam logic [1:0] S_WR_BUSY = 2'd2;

    localparam logic OWNER_RD = 1'b0;
    localparam logic OWNER_WR = 1'b1;

    logic [1:0]          r_state;
    logic                r_lastOwner;
    logic [STREAK_W-1:0] r_streak;
    logic                r_memRead;
    logic                r_memWrite;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic                r_err;

    logic                w_anyReq;
    logic                w_grantWr;
    logic [STREAK_W-1:0] w_nextStreak;

    // Pick the winner among the current requests and work out the streak it will leave behind
    always_comb begin
        w_anyReq     = rd_req_i | wr_req_i;
        w_grantWr    = OWNER_RD;
        w_nextStreak = STREAK_ONE;
        if (wr_req_i && !rd_req_i) begin
            w_grantWr = OWNER_WR;
        end else if (wr_req_i && rd_req_i) begin
            w_grantWr = (r_streak < STREAK_MAX) ? r_lastOwner : ~r_lastOwner;
        end
        if (w_grantWr == r_lastOwner) begin
            w_nextStreak = (r_streak == STREAK_MAX) ? r_streak : r_streak + STREAK_ONE;
        end
    end

    // Grant/complete state machine; the memory-side outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lastOwner <= OWNER_RD;
            r_streak    <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_lastOwner <= w_grantWr;
                        r_streak    <= w_nextStreak;
                        if (w_grantWr == OWNER_WR) begin
                            r_state    <= S_WR_BUSY;
                            r_memWrite <= 1'b1;
                            r_memAddr  <= wr_addr_i;
                            r_memWdata <= wr_data_i;
                        end else begin
                            r_state   <= S_RD_BUSY;
                            r_memRead <= 1'b1;
                            r_memAddr <= rd_addr_i;
                        end
                    end
                end
                S_RD_BUSY, S_WR_BUSY: begin
                    if (mem_resp_i) begin
                        r_state    <= S_IDLE;
                        r_memRead  <= 1'b0;
                        r_memWrite <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                end
            endcase
        end
    end

    // A completion arriving with nothing outstanding is latched as an error until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (mem_resp_i && (r_state == S_IDLE)) begin
            r_err <= 1'b1;
        end
    end

    assign rd_resp_o   = mem_resp_i & (r_state == S_RD_BUSY);
    assign rd_data_o   = mem_rdata_i;
    assign wr_resp_o   = mem_resp_i & (r_state == S_WR_BUSY);
    assign mem_read_o  = r_memRead;
    assign mem_write_o = r_memWrite;
    assign mem_addr_o  = r_memAddr;
    assign mem_wdata_o = r_memWdata;
    assign idle_o      = (r_state == S_IDLE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_he_mem_port_arbiter.sv
// Testbench for he_mem_port_arbiter.
// Two instances share all inputs: dutA uses MAX_BURST=2 and dutB uses MAX_BURST=1.
// Grant order is predicted from the arbitration rules by a small model (owner, streak).
`timescale 1ns/1ps

module tb_he_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          wr_req_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_resp_i;

    logic          aRdResp, aWrResp, aMemRead, aMemWrite, aIdle, aErr;
    logic [DW-1:0] aRdData, aMemWdata;
    logic [AW-1:0] aMemAddr;
    logic          bRdResp, bWrResp, bMemRead, bMemWrite, bIdle, bErr;
    logic [DW-1:0] bRdData, bMemWdata;
    logic [AW-1:0] bMemAddr;

    int checks   = 0;
    int failures = 0;

    int mALast, mAStreak, mBLast, mBStreak;

    he_mem_port_arbiter #(.MAX_BURST(2), .ADDR_W(AW), .DATA_W(DW)) dutA (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_resp_o(aRdResp), .rd_data_o(aRdData),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_resp_o(aWrResp),
        .mem_read_o(aMemRead), .mem_write_o(aMemWrite), .mem_addr_o(aMemAddr),
        .mem_wdata_o(aMemWdata), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
        .idle_o(aIdle), .err_o(aErr)
    );

    he_mem_port_arbiter #(.MAX_BURST(1), .ADDR_W(AW), .DATA_W(DW)) dutB (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_resp_o(bRdResp), .rd_data_o(bRdData),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_resp_o(bWrResp),
        .mem_read_o(bMemRead), .mem_write_o(bMemWrite), .mem_addr_o(bMemAddr),
        .mem_wdata_o(bMemWdata), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
        .idle_o(bIdle), .err_o(bErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitration rules: a lone requester wins; with both requesting the last owner keeps
    // the bus until it has had maxBurst grants in a row
    function automatic int predictWinner(input logic rd, input logic wr, input int last,
                                         input int streak, input int maxBurst);
        if (rd && !wr) return 0;
        if (wr && !rd) return 1;
        if (streak < maxBurst) return last;
        return 1 - last;
    endfunction

    function automatic int nextStreak(input int winner, input int last, input int streak,
                                      input int maxBurst);
        if (winner != last) return 1;
        return (streak + 1 > maxBurst) ? maxBurst : streak + 1;
    endfunction

    // Continuous protocol monitor, sampled mid low phase
    initial begin
        logic          aPrev, bPrev;
        logic [AW-1:0] aPrevAddr, bPrevAddr;
        aPrev = 1'b0; bPrev = 1'b0; aPrevAddr = '0; bPrevAddr = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst === 1'b1) begin
                checks++;
                if (aMemRead && aMemWrite) begin
                    failures++; $display("FAIL monA_excl: read=%0b write=%0b required not both", aMemRead, aMemWrite);
                end
                checks++;
                if (bMemRead && bMemWrite) begin
                    failures++; $display("FAIL monB_excl: read=%0b write=%0b required not both", bMemRead, bMemWrite);
                end
                if (aPrev && (aMemRead || aMemWrite)) begin
                    checks++;
                    if (aMemAddr !== aPrevAddr) begin
                        failures++; $display("FAIL monA_addr_stable: got %0h required %0h", aMemAddr, aPrevAddr);
                    end
                end
                if (bPrev && (bMemRead || bMemWrite)) begin
                    checks++;
                    if (bMemAddr !== bPrevAddr) begin
                        failures++; $display("FAIL monB_addr_stable: got %0h required %0h", bMemAddr, bPrevAddr);
                    end
                end
                checks++;
                if (aIdle !== !(aMemRead || aMemWrite)) begin
                    failures++; $display("FAIL monA_idle: got %0b required %0b", aIdle, !(aMemRead || aMemWrite));
                end
                checks++;
                if (bIdle !== !(bMemRead || bMemWrite)) begin
                    failures++; $display("FAIL monB_idle: got %0b required %0b", bIdle, !(bMemRead || bMemWrite));
                end
                checks++;
                if (bRdData !== mem_rdata_i) begin
                    failures++; $display("FAIL monB_rdata: got %0h required %0h", bRdData, mem_rdata_i);
                end
                checks++;
                if (bRdResp && bWrResp) begin
                    failures++; $display("FAIL monB_resp_excl: rd=%0b wr=%0b required not both", bRdResp, bWrResp);
                end
                aPrev = aMemRead | aMemWrite; aPrevAddr = aMemAddr;
                bPrev = bMemRead | bMemWrite; bPrevAddr = bMemAddr;
            end else begin
                aPrev = 1'b0;
                bPrev = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0; mem_resp_i = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Memory-side responder for one transaction: waits for the grant (bounded), holds the
    // access for lat cycles, pulses mem_resp_i and records what dutA/dutB presented
    task automatic serveTxn(input int lat, input logic [DW-1:0] rdata, input logic dropOnResp,
                            input logic raiseWr, output int waitCyc, output int ownerA,
                            output int ownerB, output logic [AW-1:0] addrA,
                            output logic [DW-1:0] wdataA, output int busy,
                            output logic rdRespA, output logic wrRespA,
                            output logic [DW-1:0] rdDataA, output logic idleAfter);
        ownerA = -1; ownerB = -1; waitCyc = 0; busy = 0; addrA = '0; wdataA = '0;
        rdRespA = 1'b0; wrRespA = 1'b0; rdDataA = '0; idleAfter = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (aMemRead || aMemWrite) begin
                waitCyc = i + 1;
                ownerA  = aMemWrite ? 1 : 0;
                break;
            end
        end
        if (ownerA < 0) return;
        ownerB = bMemWrite ? 1 : (bMemRead ? 0 : -1);
        addrA  = aMemAddr;
        wdataA = aMemWdata;
        if (raiseWr) wr_req_i = 1'b1;
        busy = 1;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            #1;
            if (aMemRead || aMemWrite) busy++;
        end
        mem_rdata_i = rdata;
        mem_resp_i  = 1'b1;
        #1;
        rdRespA = aRdResp;
        wrRespA = aWrResp;
        rdDataA = aRdData;
        if (dropOnResp) begin
            if (ownerA == 0) rd_req_i = 1'b0;
            else             wr_req_i = 1'b0;
        end
        @(negedge clk);
        mem_resp_i  = 1'b0;
        mem_rdata_i = $urandom;
        #1;
        idleAfter = aIdle & ~aMemRead & ~aMemWrite;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (aMemRead !== 1'b0) begin failures++; $display("FAIL reset_read: got %0b required 0", aMemRead); end
        checks++;
        if (aMemWrite !== 1'b0) begin failures++; $display("FAIL reset_write: got %0b required 0", aMemWrite); end
        checks++;
        if (aMemAddr !== '0) begin failures++; $display("FAIL reset_addr: got %0h required 0", aMemAddr); end
        checks++;
        if (aMemWdata !== '0) begin failures++; $display("FAIL reset_wdata: got %0h required 0", aMemWdata); end
        checks++;
        if (aErr !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b required 0", aErr); end
        checks++;
        if (aIdle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %0b required 1", aIdle); end
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        int wc, oA, oB, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rdData;
        logic rdR, wrR, idl;
        rd_addr_i = 32'h100;
        rd_req_i  = 1'b1;
        serveTxn(3, 32'hcafebabe, 1'b1, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
        checks++;
        if (oA !== 0) begin failures++; $display("FAIL read_owner: got %0d required 0", oA); end
        checks++;
        if (wc !== 1) begin failures++; $display("FAIL read_latency: got %0d required 1", wc); end
        checks++;
        if (busy !== 3) begin failures++; $display("FAIL read_busy_cycles: got %0d required 3", busy); end
        checks++;
        if (addr !== 32'h100) begin failures++; $display("FAIL read_addr: got %0h required 100", addr); end
        checks++;
        if (rdR !== 1'b1) begin failures++; $display("FAIL read_resp: got %0b required 1", rdR); end
        checks++;
        if (rdData !== 32'hcafebabe) begin failures++; $display("FAIL read_data: got %0h required cafebabe", rdData); end
        checks++;
        if (wrR !== 1'b0) begin failures++; $display("FAIL read_wr_resp: got %0b required 0", wrR); end
        checks++;
        if (idl !== 1'b1) begin failures++; $display("FAIL read_idle_after: got %0b required 1", idl); end
    endtask

    task automatic test_single_write();
        int wc, oA, oB, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rdData;
        logic rdR, wrR, idl;
        wr_addr_i = 32'h200;
        wr_data_i = 32'hdeadbeef;
        wr_req_i  = 1'b1;
        serveTxn(1, 32'h0, 1'b0, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
        checks++;
        if (oA !== 1) begin failures++; $display("FAIL write_owner: got %0d required 1", oA); end
        checks++;
        if (addr !== 32'h200) begin failures++; $display("FAIL write_addr: got %0h required 200", addr); end
        checks++;
        if (wd !== 32'hdeadbeef) begin failures++; $display("FAIL write_wdata: got %0h required deadbeef", wd); end
        checks++;
        if (wrR !== 1'b1) begin failures++; $display("FAIL write_resp: got %0b required 1", wrR); end
        checks++;
        if (rdR !== 1'b0) begin failures++; $display("FAIL write_rd_resp: got %0b required 0", rdR); end
        checks++;
        if (idl !== 1'b1) begin failures++; $display("FAIL write_idle_gap: got %0b required 1", idl); end
        serveTxn(1, 32'h0, 1'b1, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
        checks++;
        if (wc !== 1) begin failures++; $display("FAIL write_regrant_wait: got %0d required 1", wc); end
        checks++;
        if (oA !== 1) begin failures++; $display("FAIL write_regrant_owner: got %0d required 1", oA); end
    endtask

    task automatic test_spurious_resp();
        mem_resp_i = 1'b1;
        #1;
        checks++;
        if (aRdResp !== 1'b0 || aWrResp !== 1'b0) begin
            failures++; $display("FAIL spurious_route: rd=%0b wr=%0b required 0/0", aRdResp, aWrResp);
        end
        @(negedge clk);
        mem_resp_i = 1'b0;
        #1;
        checks++;
        if (aErr !== 1'b1) begin failures++; $display("FAIL spurious_err: got %0b required 1", aErr); end
        checks++;
        if (aIdle !== 1'b1) begin failures++; $display("FAIL spurious_idle: got %0b required 1", aIdle); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (aErr !== 1'b1) begin failures++; $display("FAIL spurious_sticky: got %0b required 1", aErr); end
    endtask

    task automatic test_async_reset();
        logic granted;
        granted   = 1'b0;
        wr_addr_i = 32'h300;
        wr_data_i = 32'h12345678;
        wr_req_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (aMemWrite) begin granted = 1'b1; break; end
        end
        checks++;
        if (granted !== 1'b1) begin failures++; $display("FAIL areset_grant: got %0b required 1", granted); end
        #1;
        rst      = 1'b0;
        wr_req_i = 1'b0;
        #1;
        checks++;
        if (aMemWrite !== 1'b0 || aMemRead !== 1'b0) begin
            failures++; $display("FAIL areset_strobes: read=%0b write=%0b required 0/0", aMemRead, aMemWrite);
        end
        checks++;
        if (aMemAddr !== '0 || aMemWdata !== '0) begin
            failures++; $display("FAIL areset_bus: addr=%0h wdata=%0h required 0/0", aMemAddr, aMemWdata);
        end
        checks++;
        if (aErr !== 1'b0 || bErr !== 1'b0) begin
            failures++; $display("FAIL areset_err: a=%0b b=%0b required 0/0", aErr, bErr);
        end
        checks++;
        if (aIdle !== 1'b1 || bIdle !== 1'b1) begin
            failures++; $display("FAIL areset_idle: a=%0b b=%0b required 1/1", aIdle, bIdle);
        end
        checks++;
        if (bMemWdata !== '0) begin failures++; $display("FAIL areset_b_wdata: got %0h required 0", bMemWdata); end
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_fairness();
        int wc, oA, oB, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rdData;
        logic rdR, wrR, idl;
        doReset();
        rd_addr_i = 32'h10;
        wr_addr_i = 32'h20;
        wr_data_i = 32'h55;
        rd_req_i  = 1'b1;
        wr_req_i  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            serveTxn($urandom_range(1, 3), $urandom, 1'b0, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
            checks++;
            if (oA !== ((k / 2) % 2)) begin
                failures++; $display("FAIL fair_burst2 txn%0d: got %0d required %0d", k, oA, (k / 2) % 2);
            end
            checks++;
            if (oB !== (k % 2)) begin
                failures++; $display("FAIL fair_burst1 txn%0d: got %0d required %0d", k, oB, k % 2);
            end
            checks++;
            if (addr !== ((k / 2) % 2 == 1 ? 32'h20 : 32'h10)) begin
                failures++; $display("FAIL fair_addr txn%0d: got %0h", k, addr);
            end
        end
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
    endtask

    task automatic test_streak_saturation();
        int wc, oA, oB, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rdData;
        logic rdR, wrR, idl;
        doReset();
        rd_addr_i = 32'h40;
        wr_addr_i = 32'h80;
        wr_data_i = 32'haa;
        rd_req_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serveTxn($urandom_range(1, 3), $urandom, 1'b0, (k == 4), wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
            checks++;
            if (oA !== 0 || oB !== 0) begin
                failures++; $display("FAIL streak_reads txn%0d: a=%0d b=%0d required 0/0", k, oA, oB);
            end
        end
        serveTxn(2, 32'h0, 1'b1, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
        checks++;
        if (oA !== 1) begin failures++; $display("FAIL streak_switch_a: got %0d required 1", oA); end
        checks++;
        if (oB !== 1) begin failures++; $display("FAIL streak_switch_b: got %0d required 1", oB); end
        checks++;
        if (wrR !== 1'b1) begin failures++; $display("FAIL streak_wr_resp: got %0b required 1", wrR); end
        serveTxn(1, 32'h0, 1'b1, 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
        checks++;
        if (oA !== 0) begin failures++; $display("FAIL streak_back_to_read: got %0d required 0", oA); end
    endtask

    task automatic test_random();
        int wc, oA, oB, busy, wA, wB, lat;
        logic [AW-1:0] addr, expAddr;
        logic [DW-1:0] wd, rdData, rdVal;
        logic rdR, wrR, idl;
        doReset();
        mALast = 0; mAStreak = 0; mBLast = 0; mBStreak = 0;
        for (int t = 0; t < 40; t++) begin
            if (!rd_req_i && ($urandom_range(0, 1) == 1)) begin
                rd_addr_i = $urandom;
                rd_req_i  = 1'b1;
            end
            if (!wr_req_i && ($urandom_range(0, 1) == 1)) begin
                wr_addr_i = $urandom;
                wr_data_i = $urandom;
                wr_req_i  = 1'b1;
            end
            if (!rd_req_i && !wr_req_i) begin
                rd_addr_i = $urandom;
                rd_req_i  = 1'b1;
            end
            wA = predictWinner(rd_req_i, wr_req_i, mALast, mAStreak, 2);
            wB = predictWinner(rd_req_i, wr_req_i, mBLast, mBStreak, 1);
            expAddr = (wA == 1) ? wr_addr_i : rd_addr_i;
            lat   = $urandom_range(1, 4);
            rdVal = $urandom;
            serveTxn(lat, rdVal, ($urandom_range(0, 1) == 1), 1'b0, wc, oA, oB, addr, wd, busy, rdR, wrR, rdData, idl);
            checks++;
            if (oA !== wA) begin failures++; $display("FAIL rand_owner_a txn%0d: got %0d required %0d", t, oA, wA); end
            checks++;
            if (oB !== wB) begin failures++; $display("FAIL rand_owner_b txn%0d: got %0d required %0d", t, oB, wB); end
            checks++;
            if (addr !== expAddr) begin failures++; $display("FAIL rand_addr txn%0d: got %0h required %0h", t, addr, expAddr); end
            checks++;
            if (busy !== lat) begin failures++; $display("FAIL rand_busy txn%0d: got %0d required %0d", t, busy, lat); end
            if (wA == 1) begin
                checks++;
                if (wd !== wr_data_i) begin failures++; $display("FAIL rand_wdata txn%0d: got %0h required %0h", t, wd, wr_data_i); end
                checks++;
                if (wrR !== 1'b1 || rdR !== 1'b0) begin
                    failures++; $display("FAIL rand_wr_resp txn%0d: wr=%0b rd=%0b required 1/0", t, wrR, rdR);
                end
            end else begin
                checks++;
                if (rdR !== 1'b1 || wrR !== 1'b0) begin
                    failures++; $display("FAIL rand_rd_resp txn%0d: rd=%0b wr=%0b required 1/0", t, rdR, wrR);
                end
                checks++;
                if (rdData !== rdVal) begin failures++; $display("FAIL rand_rdata txn%0d: got %0h required %0h", t, rdData, rdVal); end
            end
            checks++;
            if (idl !== 1'b1) begin failures++; $display("FAIL rand_idle_after txn%0d: got %0b required 1", t, idl); end
            mAStreak = nextStreak(wA, mALast, mAStreak, 2); mALast = wA;
            mBStreak = nextStreak(wB, mBLast, mBStreak, 1); mBLast = wB;
        end
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
    endtask

    // Test sequence
    initial begin
        rst = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0; mem_resp_i = 1'b0;
        rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0; mem_rdata_i = '0;
        $display("[TB] start");
        test_reset();
        test_single_read();
        test_single_write();
        test_spurious_resp();
        test_async_reset();
        test_fairness();
        test_streak_saturation();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
